// File: rtl/syscall_io.sv
// SYSCALL service unit: decodes the syscall number in ACC and runs HALT, READ or WRITE
// against the host word streams. Drops iobusy for one DONE cycle so the controller can retire.
module syscall_io #(
  parameter int W = 16
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         runio,
  input  logic [W-1:0] acc,
  input  logic [W-1:0] dr,
  output logic         iobusy,
  output logic [W-1:0] io_data,
  output logic         io_we,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic         halted
);

  // Streams: a word moves on the rising edge where valid and ready are both high;
  // out_valid is held until that edge and ready/valid are only offered in READ/WRITE.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_READ  = 3'd1,
    ST_WRITE = 3'd2,
    ST_HALT  = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  localparam logic [W-1:0] SYS_HALT  = W'(0);
  localparam logic [W-1:0] SYS_READ  = W'(1);
  localparam logic [W-1:0] SYS_WRITE = W'(2);

  state_t       state_q, state_d;
  logic         op_read_q, op_read_d;
  logic [W-1:0] io_data_q, io_data_d;
  logic [W-1:0] out_data_q, out_data_d;
  logic         halted_q, halted_d;

  always_comb begin
    state_d    = state_q;
    op_read_d  = op_read_q;
    io_data_d  = io_data_q;
    out_data_d = out_data_q;
    halted_d   = halted_q;
    case (state_q)
      ST_IDLE: begin
        if (runio) begin
          if (acc == SYS_HALT) begin
            state_d  = ST_HALT;
            halted_d = 1'b1;
          end else if (acc == SYS_READ) begin
            state_d = ST_READ;
          end else if (acc == SYS_WRITE) begin
            state_d    = ST_WRITE;
            out_data_d = dr;
          end else begin
            // Unknown syscall numbers retire as a NOP
            state_d   = ST_DONE;
            op_read_d = 1'b0;
          end
        end
      end
      ST_READ: begin
        if (in_valid) begin
          io_data_d = in_data;
          op_read_d = 1'b1;
          state_d   = ST_DONE;
        end
      end
      ST_WRITE: begin
        if (out_ready) begin
          op_read_d = 1'b0;
          state_d   = ST_DONE;
        end
      end
      ST_HALT: begin
        halted_d = 1'b1;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      op_read_q  <= 1'b0;
      io_data_q  <= '0;
      out_data_q <= '0;
      halted_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_read_q  <= op_read_d;
      io_data_q  <= io_data_d;
      out_data_q <= out_data_d;
      halted_q   <= halted_d;
    end
  end

  // iobusy is combinational so it is already high in the cycle runio first rises
  assign iobusy    = runio & (state_q != ST_DONE);
  assign io_we     = (state_q == ST_DONE) & op_read_q;
  assign in_ready  = (state_q == ST_READ);
  assign out_valid = (state_q == ST_WRITE);
  assign io_data   = io_data_q;
  assign out_data  = out_data_q;
  assign halted    = halted_q;

endmodule

// File: tb/tb_syscall_io.sv
// Bench for syscall_io: transaction-level reference model with randomized syscalls,
// stream-delay and reset scenarios; output words are scoreboarded through exp_q.
module tb_syscall_io;
  localparam int W = 16;

  logic         clock = 1'b0;
  logic         reset;
  logic         runio;
  logic [W-1:0] acc;
  logic [W-1:0] dr;
  logic         iobusy;
  logic [W-1:0] io_data;
  logic         io_we;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;
  logic         halted;

  int n_checks = 0;
  int n_pass   = 0;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] m_io_data;
  logic [W-1:0] m_out_data;

  syscall_io #(.W(W)) dut (
    .clock     (clock),
    .reset     (reset),
    .runio     (runio),
    .acc       (acc),
    .dr        (dr),
    .iobusy    (iobusy),
    .io_data   (io_data),
    .io_we     (io_we),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .halted    (halted)
  );

  // ---------------- clock ----------------
  always #5 clock = ~clock;

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  function automatic logic [31:0] flag_vec(input logic b, input logic we, input logic ir,
                                           input logic ov, input logic h);
    return {27'b0, b, we, ir, ov, h};
  endfunction

  // Output-stream scoreboard: every accepted word must match the next WRITE payload
  always @(negedge clock) begin : out_monitor
    logic [W-1:0] e;
    if (reset === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("out_unexpected", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("out_word", 32'(out_data), 32'(e));
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Reset held for 'cycles' edges with stream handshakes offered; nothing may move.
  task automatic apply_reset(input int cycles, input logic hold_runio);
    reset     = 1'b0;
    runio     = hold_runio;
    acc       = W'($urandom);
    dr        = W'($urandom);
    in_data   = W'($urandom);
    in_valid  = 1'b1;
    out_ready = 1'b1;
    exp_q.delete();
    m_io_data  = '0;
    m_out_data = '0;
    for (int c = 0; c < cycles; c++) begin
      @(posedge clock);
      @(negedge clock);
      check("rst_flags", flag_vec(iobusy, io_we, in_ready, out_valid, halted),
            flag_vec(hold_runio, 1'b0, 1'b0, 1'b0, 1'b0));
      check("rst_io_data", 32'(io_data), 32'(m_io_data));
      check("rst_out_data", 32'(out_data), 32'(m_out_data));
    end
    @(posedge clock);
    #1;
    reset     = 1'b1;
    runio     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
  endtask

  // One non-HALT syscall; the stream partner answers 'dly' cycles after the unit offers it.
  task automatic do_syscall(input logic [W-1:0] a, input logic [W-1:0] d,
                            input logic [W-1:0] w, input int dly);
    logic is_rd, is_wr;
    int   done_c;
    is_rd  = (a == 16'd1);
    is_wr  = (a == 16'd2);
    done_c = (is_rd || is_wr) ? 2 + dly : 1;
    if (is_wr) begin
      exp_q.push_back(d);
      m_out_data = d;
    end
    runio = 1'b1;
    acc   = a;
    for (int c = 0; c <= done_c; c++) begin
      if (c == 0) begin
        dr        = d;
        in_valid  = 1'($urandom_range(0, 1));
        out_ready = 1'($urandom_range(0, 1));
      end else begin
        dr        = W'($urandom);
        in_valid  = is_rd && (c >= 1 + dly);
        out_ready = is_wr && (c >= 1 + dly);
      end
      in_data = (c == 1 + dly) ? w : W'($urandom);
      @(negedge clock);
      check("flags", flag_vec(iobusy, io_we, in_ready, out_valid, halted),
            flag_vec(c < done_c, is_rd && c == done_c, is_rd && c >= 1 && c < done_c,
                     is_wr && c >= 1 && c < done_c, 1'b0));
      if (is_wr && c >= 1) check("out_data_hold", 32'(out_data), 32'(d));
      if (c == done_c) begin
        if (is_rd) m_io_data = w;
        check("done_io_data", 32'(io_data), 32'(m_io_data));
      end
      @(posedge clock);
      #1;
    end
    runio     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    @(negedge clock);
    check("idle_flags", flag_vec(iobusy, io_we, in_ready, out_valid, halted),
          flag_vec(1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    check("idle_io_data", 32'(io_data), 32'(m_io_data));
    check("idle_out_data", 32'(out_data), 32'(m_out_data));
    @(posedge clock);
    #1;
  endtask

  // HALT never completes: iobusy stays high while runio is held, then reset recovers.
  task automatic do_halt(input int hold_cycles);
    runio     = 1'b1;
    acc       = '0;
    dr        = W'($urandom);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    @(negedge clock);
    check("halt_entry", flag_vec(iobusy, io_we, in_ready, out_valid, halted),
          flag_vec(1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
    for (int c = 0; c < hold_cycles; c++) begin
      @(posedge clock);
      #1;
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 1));
      acc       = W'($urandom_range(0, 3));
      @(negedge clock);
      check("halt_hold", flag_vec(iobusy, io_we, in_ready, out_valid, halted),
            flag_vec(1'b1, 1'b0, 1'b0, 1'b0, 1'b1));
    end
    @(posedge clock);
    #1;
    apply_reset(2, 1'b1);
  endtask

  // WRITE stalled by the host, then aborted by reset with ready offered at the reset edge.
  task automatic write_then_reset(input logic [W-1:0] d, input int stall);
    runio     = 1'b1;
    acc       = 16'd2;
    dr        = d;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    exp_q.push_back(d);
    for (int c = 0; c <= stall; c++) begin
      @(negedge clock);
      if (c >= 1) begin
        check("stall_out_valid", 32'(out_valid), 32'd1);
        check("stall_out_data", 32'(out_data), 32'(d));
      end
      @(posedge clock);
      #1;
      dr = W'($urandom);
    end
    apply_reset(1, 1'b1);
  endtask

  // ---------------- main sequence ----------------
  initial begin : main
    logic [W-1:0] a;
    int sel;
    reset     = 1'b0;
    runio     = 1'b0;
    acc       = '0;
    dr        = '0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    m_io_data  = '0;
    m_out_data = '0;

    apply_reset(3, 1'b0);

    do_syscall(16'd1, 16'h0000, 16'h1234, 3);
    do_syscall(16'd2, 16'hBEEF, 16'h0000, 4);
    do_syscall(16'd7, 16'h5555, 16'h0000, 0);
    do_syscall(16'd1, 16'h0000, 16'hA5A5, 0);
    do_syscall(16'd2, 16'h0F0F, 16'h0000, 0);
    do_syscall(16'h0101, 16'h3333, 16'h0000, 0);
    do_syscall(16'h8002, 16'h4444, 16'h0000, 0);

    do_halt(22);
    write_then_reset(16'hCAFE, 3);
    do_syscall(16'd1, 16'h0000, 16'h7E57, 1);

    for (int i = 0; i < 40; i++) begin
      sel = $urandom_range(0, 5);
      case (sel)
        0, 1:    a = 16'd1;
        2, 3:    a = 16'd2;
        4:       a = W'($urandom_range(3, 65535));
        default: a = 16'h0100 | W'($urandom_range(0, 2)) | (W'($urandom_range(1, 127)) << 9);
      endcase
      do_syscall(a, W'($urandom), W'($urandom), $urandom_range(0, 4));
    end

    do_halt(20);
    do_syscall(16'd2, 16'h1357, 16'h0000, 2);

    check("exp_q_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
